// File: rtl/nic2noc_egress_alloc_pkg.sv
// Shared definitions for the NIC-to-NoC egress allocator.
// Holds the default geometry (virtual networks, VCs per network, output
// buffers, flit width), a clog2 helper that never returns less than 1,
// and the VC index helper used to flatten (vn, vc) pairs.
package nic2noc_egress_alloc_pkg;

  localparam int DEFAULT_N_OF_VN           = 2;
  localparam int DEFAULT_N_OF_VC           = 2;
  localparam int DEFAULT_N_FIFO_OUT_BUFFER = 4;
  localparam int DEFAULT_FLIT_WIDTH        = 32;

  // Bits needed to hold an id in 0..n-1; at least one bit so that a
  // single-buffer configuration still has a legal id field.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Flat router VC index of VC 'vc' inside virtual network 'vn'.
  function automatic int vc_index(input int vn, input int vc, input int n_of_vc);
    return vn * n_of_vc + vc;
  endfunction

endpackage

// File: rtl/nic2noc_egress_alloc_if.sv
// Bundle of the allocator's NIC-side and router-side signals.
//   slave  : the allocator itself (takes requests/credits/flits, drives grants,
//            forwarded credits, link flits and VC busy state).
//   master : the environment driving requests, credits and flits.
// Signal names and meanings:
//   credit_signal_i / free_signal_i   router credit / VC-drained pulses per VC
//   out_link_o / is_valid_o           registered flit to the router
//   r_la_i, g_la_o, g_la_channel_id_o link request per buffer, grant, winner id
//   r_va_i, r_vc_requested_i          VC request per buffer and acceptable-VC masks
//   g_va_o, g_vc_id_o                 VC grant per buffer and one-hot granted VC
//   release_pointer_i                 NIC finished with VC
//   credit_signal_o, fifo_pointed_o   forwarded credit and its owner buffer id
//   in_link_i / is_valid_i            flit from the granted buffer
//   fifo_pointer_state_o              1 = VC busy
interface nic2noc_egress_alloc_if
  import nic2noc_egress_alloc_pkg::*;
#(
  parameter int N_TOT_OF_VC       = DEFAULT_N_OF_VN * DEFAULT_N_OF_VC,
  parameter int N_FIFO_OUT_BUFFER = DEFAULT_N_FIFO_OUT_BUFFER,
  parameter int N_BITS_POINTER    = clog2(DEFAULT_N_FIFO_OUT_BUFFER),
  parameter int FLIT_WIDTH        = DEFAULT_FLIT_WIDTH
);

  logic [N_TOT_OF_VC-1:0]                   credit_signal_i;
  logic [N_TOT_OF_VC-1:0]                   free_signal_i;
  logic [FLIT_WIDTH-1:0]                    out_link_o;
  logic                                     is_valid_o;
  logic [N_FIFO_OUT_BUFFER-1:0]             r_la_i;
  logic                                     g_la_o;
  logic [N_BITS_POINTER-1:0]                g_la_channel_id_o;
  logic [N_FIFO_OUT_BUFFER-1:0]             r_va_i;
  logic [N_FIFO_OUT_BUFFER*N_TOT_OF_VC-1:0] r_vc_requested_i;
  logic [N_FIFO_OUT_BUFFER-1:0]             g_va_o;
  logic [N_FIFO_OUT_BUFFER*N_TOT_OF_VC-1:0] g_vc_id_o;
  logic [N_TOT_OF_VC-1:0]                   release_pointer_i;
  logic [N_TOT_OF_VC-1:0]                   credit_signal_o;
  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0]    fifo_pointed_o;
  logic [FLIT_WIDTH-1:0]                    in_link_i;
  logic                                     is_valid_i;
  logic [N_TOT_OF_VC-1:0]                   fifo_pointer_state_o;

  modport slave (
    input  credit_signal_i, free_signal_i, r_la_i, r_va_i, r_vc_requested_i,
           release_pointer_i, in_link_i, is_valid_i,
    output out_link_o, is_valid_o, g_la_o, g_la_channel_id_o, g_va_o, g_vc_id_o,
           credit_signal_o, fifo_pointed_o, fifo_pointer_state_o
  );

  modport master (
    output credit_signal_i, free_signal_i, r_la_i, r_va_i, r_vc_requested_i,
           release_pointer_i, in_link_i, is_valid_i,
    input  out_link_o, is_valid_o, g_la_o, g_la_channel_id_o, g_va_o, g_vc_id_o,
           credit_signal_o, fifo_pointed_o, fifo_pointer_state_o
  );

endinterface

// File: rtl/nic2noc_egress_alloc_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority position (0..N-1)
//   grant : one-hot grant of the first requester at or after ptr, circularly
//   id    : binary index of that requester, 0 when nothing is requested
module nic2noc_egress_alloc_rr_arbiter
  import nic2noc_egress_alloc_pkg::*;
#(
  parameter int N = DEFAULT_N_FIFO_OUT_BUFFER,
  parameter int W = clog2(DEFAULT_N_FIFO_OUT_BUFFER)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] id
);

  // Scan from the farthest position back towards ptr so the last hit
  // written is the one nearest to ptr; no found-flag is needed.
  always_comb begin
    grant = '0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant                      = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        id                         = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/nic2noc_egress_alloc.sv
// NIC egress back-end: VC allocation, link allocation, credit routing and
// the registered flit link towards the router input port.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : nic2noc_egress_alloc_if.slave (requests, grants, credits,
//              flits and VC busy state; see the interface file)
// VC allocation and link allocation are combinational from the current
// state; all state (VC table, pointers, credit and link registers) updates
// on the rising clock edge.
module nic2noc_egress_alloc
  import nic2noc_egress_alloc_pkg::*;
#(
  parameter int N_OF_VN           = DEFAULT_N_OF_VN,
  parameter int N_OF_VC           = DEFAULT_N_OF_VC,
  parameter int N_FIFO_OUT_BUFFER = DEFAULT_N_FIFO_OUT_BUFFER,
  parameter int FLIT_WIDTH        = DEFAULT_FLIT_WIDTH,
  localparam int N_TOT_OF_VC      = N_OF_VN * N_OF_VC,
  localparam int N_BITS_POINTER   = clog2(N_FIFO_OUT_BUFFER)
) (
  input logic                   clk,
  input logic                   rst,
  nic2noc_egress_alloc_if.slave bus
);

  localparam int NV = N_TOT_OF_VC;
  localparam int NB = N_FIFO_OUT_BUFFER;
  localparam int PW = N_BITS_POINTER;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) + 1 >= NB) ? '0 : p + PW'(1);
  endfunction

  // VC table and arbitration pointers
  logic [NV-1:0] owned_q;
  logic [NV-1:0] ds_free_q;
  logic [PW-1:0] owner_q [NV];
  logic [PW-1:0] va_ptr_q;
  logic [PW-1:0] la_ptr_q;

  // Registered router-side outputs
  logic [NV-1:0]         credit_p1;
  logic [NV*PW-1:0]      pointed_p1;
  logic [FLIT_WIDTH-1:0] flit_p1;
  logic                  vld_p1;

  logic [NV-1:0] busy;
  assign busy = owned_q | ~ds_free_q;

  // VC allocation: buffers are served one after another in round-robin
  // order from va_ptr; each takes the lowest free VC its mask allows that
  // an earlier buffer in this cycle has not already taken.
  logic [NV-1:0]    vc_taken;
  logic [NV-1:0]    avail;
  logic [NV-1:0]    pick;
  logic [NB-1:0]    va_grant;
  logic [NB*NV-1:0] vc_grant_flat;
  int               vb;

  always_comb begin
    vc_taken      = '0;
    avail         = '0;
    pick          = '0;
    va_grant      = '0;
    vc_grant_flat = '0;
    vb            = 0;
    for (int k = 0; k < NB; k++) begin
      vb    = (int'(va_ptr_q) + k) % NB;
      avail = bus.r_vc_requested_i[vb*NV +: NV] & ~busy & ~vc_taken;
      // Isolate the lowest set bit of avail.
      pick  = avail & (~avail + NV'(1));
      if (bus.r_va_i[vb] && (avail != '0)) begin
        va_grant[vb]               = 1'b1;
        vc_grant_flat[vb*NV +: NV] = pick;
        vc_taken                   = vc_taken | pick;
      end
    end
  end

  // The first granted buffer in round-robin order sets the next va_ptr.
  logic [NB-1:0] va_first_grant;
  logic [PW-1:0] va_first_id;

  nic2noc_egress_alloc_rr_arbiter #(.N(NB), .W(PW)) u_va_order (
    .req   (va_grant),
    .ptr   (va_ptr_q),
    .grant (va_first_grant),
    .id    (va_first_id)
  );

  // Link allocation.
  logic [NB-1:0] la_grant;
  logic [PW-1:0] la_id;

  nic2noc_egress_alloc_rr_arbiter #(.N(NB), .W(PW)) u_link_arb (
    .req   (bus.r_la_i),
    .ptr   (la_ptr_q),
    .grant (la_grant),
    .id    (la_id)
  );

  // ---- stage p0 -> p1: VC table, pointers, credit and link registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      owned_q    <= '0;
      ds_free_q  <= '1;
      va_ptr_q   <= '0;
      la_ptr_q   <= '0;
      credit_p1  <= '0;
      pointed_p1 <= '0;
      flit_p1    <= '0;
      vld_p1     <= 1'b0;
      for (int i = 0; i < NV; i++) owner_q[i] <= '0;
    end else begin
      // A fresh grant wins over release/free on the same VC; in practice
      // they cannot meet because busy blocks the grant.
      owned_q   <= (owned_q & ~bus.release_pointer_i) | vc_taken;
      ds_free_q <= (ds_free_q | bus.free_signal_i) & ~vc_taken;
      for (int i = 0; i < NV; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (vc_grant_flat[b*NV + i]) owner_q[i] <= PW'(b);
        end
      end
      if (|va_first_grant) va_ptr_q <= ptr_inc(va_first_id);
      if (|la_grant)       la_ptr_q <= ptr_inc(la_id);

      // Credits are tagged with the owner held before this edge, so a
      // credit coinciding with a new grant returns to the previous owner.
      credit_p1 <= bus.credit_signal_i;
      for (int i = 0; i < NV; i++) pointed_p1[i*PW +: PW] <= owner_q[i];

      vld_p1 <= bus.is_valid_i;
      if (bus.is_valid_i) flit_p1 <= bus.in_link_i;
    end
  end

  assign bus.g_va_o               = va_grant;
  assign bus.g_vc_id_o            = vc_grant_flat;
  assign bus.g_la_o               = |la_grant;
  assign bus.g_la_channel_id_o    = la_id;
  assign bus.fifo_pointer_state_o = busy;
  assign bus.credit_signal_o      = credit_p1;
  assign bus.fifo_pointed_o       = pointed_p1;
  assign bus.out_link_o           = flit_p1;
  assign bus.is_valid_o           = vld_p1;

endmodule

// File: tb/tb_nic2noc_egress_alloc.sv
module tb_nic2noc_egress_alloc;
  import nic2noc_egress_alloc_pkg::*;

  localparam int NV = 4;
  localparam int NB = 4;
  localparam int PW = 2;
  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nic2noc_egress_alloc_if #(
    .N_TOT_OF_VC(NV), .N_FIFO_OUT_BUFFER(NB), .N_BITS_POINTER(PW), .FLIT_WIDTH(FW)
  ) bus ();

  nic2noc_egress_alloc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  bit          m_owned  [NV];
  bit          m_dsfree [NV];
  int          m_owner  [NV];
  int          m_va_ptr;
  int          m_la_ptr;
  int          m_gvc    [NB];   // granted VC index per buffer, -1 if none
  int          m_first;
  int          m_la_id;
  bit          m_la_any;
  logic [NV-1:0]    e_credit;
  int               e_ptd [NV];
  logic [FW-1:0]    e_link;
  logic             e_valid;
  logic [NB-1:0]    e_gva;
  logic [NB*NV-1:0] e_gvc;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_owned[i] = 0; m_dsfree[i] = 1; m_owner[i] = 0; e_ptd[i] = 0;
    end
    m_va_ptr = 0; m_la_ptr = 0;
    e_credit = '0; e_link = '0; e_valid = 1'b0;
  endtask

  function automatic logic [NV-1:0] model_busy();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_owned[i] || !m_dsfree[i];
    return r;
  endfunction

  function automatic logic [NV*PW-1:0] model_ptd();
    logic [NV*PW-1:0] r;
    for (int i = 0; i < NV; i++) r[i*PW +: PW] = PW'(e_ptd[i]);
    return r;
  endfunction

  // Grants computed from the allocation rules on the current inputs.
  task automatic model_comb();
    bit taken [NV];
    int order [$];
    int b;
    for (int i = 0; i < NV; i++) taken[i] = 0;
    for (int k = 0; k < NB; k++) order.push_back((m_va_ptr + k) % NB);
    m_first = -1;
    e_gva = '0;
    e_gvc = '0;
    foreach (order[j]) begin
      b = order[j];
      m_gvc[b] = -1;
      if (bus.r_va_i[b]) begin
        for (int i = 0; i < NV; i++) begin
          if (m_gvc[b] < 0 && bus.r_vc_requested_i[b*NV + i] && m_dsfree[i] &&
              !m_owned[i] && !taken[i]) begin
            m_gvc[b] = i;
            taken[i] = 1;
          end
        end
        if (m_gvc[b] >= 0) begin
          e_gva[b] = 1'b1;
          e_gvc[b*NV + m_gvc[b]] = 1'b1;
          if (m_first < 0) m_first = b;
        end
      end
    end
    m_la_any = |bus.r_la_i;
    m_la_id  = 0;
    for (int k = 0; k < NB; k++) begin
      if (bus.r_la_i[(m_la_ptr + k) % NB]) begin
        m_la_id = (m_la_ptr + k) % NB;
        break;
      end
    end
  endtask

  // State update at a rising edge, from the inputs present at that edge.
  task automatic model_step();
    bit granted [NV];
    if (rst) begin
      model_reset();
      return;
    end
    model_comb();
    e_credit = bus.credit_signal_i;
    for (int i = 0; i < NV; i++) begin
      e_ptd[i] = m_owner[i];
      granted[i] = 0;
    end
    if (bus.is_valid_i) e_link = bus.in_link_i;
    e_valid = bus.is_valid_i;
    for (int b = 0; b < NB; b++) begin
      if (m_gvc[b] >= 0) begin
        granted[m_gvc[b]] = 1;
        m_owned[m_gvc[b]] = 1;
        m_dsfree[m_gvc[b]] = 0;
        m_owner[m_gvc[b]] = b;
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (!granted[i] && bus.release_pointer_i[i]) m_owned[i] = 0;
      if (!granted[i] && bus.free_signal_i[i])     m_dsfree[i] = 1;
    end
    if (m_first >= 0) m_va_ptr = (m_first + 1) % NB;
    if (m_la_any)     m_la_ptr = (m_la_id + 1) % NB;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.credit_signal_i   = '0;
    bus.free_signal_i     = '0;
    bus.r_la_i            = '0;
    bus.r_va_i            = '0;
    bus.r_vc_requested_i  = '0;
    bus.release_pointer_i = '0;
    bus.in_link_i         = '0;
    bus.is_valid_i        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.fifo_pointer_state_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state got %b want 0000", bus.fifo_pointer_state_o);
    end
    n_tests++;
    if (bus.credit_signal_o !== 4'b0000 || bus.fifo_pointed_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_credit got %b/%h want 0000/00", bus.credit_signal_o, bus.fifo_pointed_o);
    end
    n_tests++;
    if (bus.out_link_o !== 32'h0 || bus.is_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_link got %h/%b want 0/0", bus.out_link_o, bus.is_valid_o);
    end
    n_tests++;
    if (bus.g_la_o !== 1'b0 || bus.g_la_channel_id_o !== 2'd0 || bus.g_va_o !== 4'b0) begin
      n_fail++; $display("FAIL reset_grants got la=%b id=%0d va=%b want 0 0 0000",
                         bus.g_la_o, bus.g_la_channel_id_o, bus.g_va_o);
    end
  endtask

  task automatic test_va_basic();
    do_reset();
    bus.r_va_i = 4'b0001;
    bus.r_vc_requested_i = 16'h0003;
    @(negedge clk);
    n_tests++;
    if (bus.g_va_o !== 4'b0001 || bus.g_vc_id_o[3:0] !== 4'b0001) begin
      n_fail++; $display("FAIL va_basic_grant got %b/%b want 0001/0001", bus.g_va_o, bus.g_vc_id_o[3:0]);
    end
    tick();
    idle();
    n_tests++;
    if (bus.fifo_pointer_state_o !== 4'b0001) begin
      n_fail++; $display("FAIL va_basic_state got %b want 0001", bus.fifo_pointer_state_o);
    end
  endtask

  task automatic test_va_contention();
    do_reset();
    bus.r_va_i = 4'b0011;
    bus.r_vc_requested_i = 16'h0033;
    @(negedge clk);
    n_tests++;
    if (bus.g_va_o !== 4'b0011 || bus.g_vc_id_o[3:0] !== 4'b0001 || bus.g_vc_id_o[7:4] !== 4'b0010) begin
      n_fail++; $display("FAIL va_two_grant got va=%b vc=%h want 0011 vc=0021", bus.g_va_o, bus.g_vc_id_o);
    end
    tick();
    bus.r_va_i = 4'b0100;
    bus.r_vc_requested_i = 16'h0300;
    @(negedge clk);
    n_tests++;
    if (bus.fifo_pointer_state_o !== 4'b0011) begin
      n_fail++; $display("FAIL va_two_state got %b want 0011", bus.fifo_pointer_state_o);
    end
    n_tests++;
    if (bus.g_va_o !== 4'b0000 || bus.g_vc_id_o !== 16'h0) begin
      n_fail++; $display("FAIL va_exhausted got va=%b vc=%h want 0000 0000", bus.g_va_o, bus.g_vc_id_o);
    end
    tick();
    idle();
  endtask

  task automatic test_credit_release();
    do_reset();
    bus.r_va_i = 4'b0100;
    bus.r_vc_requested_i = 16'h0100;
    @(negedge clk);
    n_tests++;
    if (bus.g_va_o !== 4'b0100 || bus.g_vc_id_o[11:8] !== 4'b0001) begin
      n_fail++; $display("FAIL credit_setup got va=%b vc=%h want 0100 0100", bus.g_va_o, bus.g_vc_id_o);
    end
    tick();
    idle();
    bus.credit_signal_i = 4'b0001;
    tick();
    bus.credit_signal_i = 4'b0000;
    n_tests++;
    if (bus.credit_signal_o !== 4'b0001 || bus.fifo_pointed_o[1:0] !== 2'd2) begin
      n_fail++; $display("FAIL credit_route got %b/%0d want 0001/2", bus.credit_signal_o, bus.fifo_pointed_o[1:0]);
    end
    bus.release_pointer_i = 4'b0001;
    tick();
    bus.release_pointer_i = 4'b0000;
    n_tests++;
    if (bus.fifo_pointer_state_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL release_only got %b want 1", bus.fifo_pointer_state_o[0]);
    end
    bus.free_signal_i = 4'b0001;
    tick();
    bus.free_signal_i = 4'b0000;
    n_tests++;
    if (bus.fifo_pointer_state_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL release_free got %b want 0", bus.fifo_pointer_state_o[0]);
    end
  endtask

  task automatic test_link_alloc();
    do_reset();
    bus.r_la_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.g_la_o !== 1'b1 || bus.g_la_channel_id_o !== 2'(k % 4)) begin
        n_fail++; $display("FAIL la_seq step %0d got g=%b id=%0d want 1 %0d",
                           k, bus.g_la_o, bus.g_la_channel_id_o, k % 4);
      end
      tick();
    end
    bus.r_la_i = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (bus.g_la_o !== 1'b0 || bus.g_la_channel_id_o !== 2'd0) begin
      n_fail++; $display("FAIL la_none got g=%b id=%0d want 0 0", bus.g_la_o, bus.g_la_channel_id_o);
    end
  endtask

  task automatic test_link_data();
    logic [FW-1:0] words [3];
    logic [FW-1:0] want;
    int vcount;
    words[0] = 32'hBBB10000;
    words[1] = 32'hDDD1CCC1;
    words[2] = 32'h0000FFF2;
    vcount = 0;
    idle();
    for (int k = 0; k < 6; k++) begin
      bus.in_link_i  = (k < 3) ? words[k] : $urandom;
      bus.is_valid_i = (k < 3);
      tick();
      want = (k < 3) ? words[k] : words[2];
      if (bus.is_valid_o === 1'b1) vcount++;
      n_tests++;
      if (bus.out_link_o !== want || bus.is_valid_o !== (k < 3)) begin
        n_fail++; $display("FAIL link_data step %0d got %h/%b want %h/%b",
                           k, bus.out_link_o, bus.is_valid_o, want, (k < 3));
      end
    end
    idle();
    n_tests++;
    if (vcount != 3) begin
      n_fail++; $display("FAIL link_valid_len got %0d want 3", vcount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.r_va_i            = 4'($urandom);
      bus.r_vc_requested_i  = 16'($urandom);
      bus.release_pointer_i = 4'($urandom & $urandom);
      bus.free_signal_i     = 4'($urandom & $urandom);
      bus.credit_signal_i   = 4'($urandom);
      bus.r_la_i            = 4'($urandom & $urandom);
      bus.in_link_i         = $urandom;
      bus.is_valid_i        = 1'($urandom);
      @(negedge clk);
      model_comb();
      n_tests++;
      if (bus.g_va_o !== e_gva || bus.g_vc_id_o !== e_gvc) begin
        n_fail++; $display("FAIL rand_va cyc %0d got %b/%h want %b/%h", c, bus.g_va_o, bus.g_vc_id_o, e_gva, e_gvc);
      end
      n_tests++;
      if (bus.g_la_o !== m_la_any || bus.g_la_channel_id_o !== 2'(m_la_id)) begin
        n_fail++; $display("FAIL rand_la cyc %0d got %b/%0d want %b/%0d", c, bus.g_la_o, bus.g_la_channel_id_o, m_la_any, m_la_id);
      end
      n_tests++;
      if (bus.fifo_pointer_state_o !== model_busy()) begin
        n_fail++; $display("FAIL rand_state cyc %0d got %b want %b", c, bus.fifo_pointer_state_o, model_busy());
      end
      n_tests++;
      if (bus.credit_signal_o !== e_credit || bus.fifo_pointed_o !== model_ptd()) begin
        n_fail++; $display("FAIL rand_credit cyc %0d got %b/%h want %b/%h", c, bus.credit_signal_o, bus.fifo_pointed_o, e_credit, model_ptd());
      end
      n_tests++;
      if (bus.out_link_o !== e_link || bus.is_valid_o !== e_valid) begin
        n_fail++; $display("FAIL rand_link cyc %0d got %h/%b want %h/%b", c, bus.out_link_o, bus.is_valid_o, e_link, e_valid);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.r_va_i = 4'b0010;
    bus.r_vc_requested_i = 16'h0010;
    tick();
    bus.r_va_i = 4'b1111;
    bus.r_vc_requested_i = 16'hFFFF;
    tick();
    bus.credit_signal_i = 4'b1111;
    bus.is_valid_i = 1'b1;
    bus.in_link_i = 32'hA5A5A5A5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_tests++;
    if (bus.fifo_pointer_state_o !== 4'b0000 || bus.credit_signal_o !== 4'b0000 || bus.is_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got state=%b cred=%b vld=%b want 0000 0000 0",
                         bus.fifo_pointer_state_o, bus.credit_signal_o, bus.is_valid_o);
    end
    bus.r_va_i = 4'b0011;
    bus.r_vc_requested_i = 16'h0011;
    @(negedge clk);
    n_tests++;
    if (bus.g_va_o !== 4'b0001 || bus.g_vc_id_o[7:0] !== 8'h01) begin
      n_fail++; $display("FAIL rst_mid_ptr got va=%b vc=%h want 0001 01", bus.g_va_o, bus.g_vc_id_o[7:0]);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_va_basic();
    test_va_contention();
    test_credit_release();
    test_link_alloc();
    test_link_data();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
